// File: rtl/uart_fifos_if.sv
// rtl/uart_fifos_if.sv - handshake bundle between uart_fifos and the UART engines / CPU MMIO path
interface uart_fifos_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] io_rx_data_in;
    logic             io_rx_data_in_valid;
    logic             io_rx_data_in_ready;
    logic             io_rx_pop;
    logic [WIDTH-1:0] io_rx_fifo_out;
    logic             io_rx_fifo_empty;
    logic             io_tx_wr_en;
    logic [WIDTH-1:0] io_tx_wr_data;
    logic             io_tx_fifo_full;
    logic [WIDTH-1:0] io_tx_data_out;
    logic             io_tx_data_out_valid;
    logic             io_tx_data_out_ready;
`ifdef UART_FIFOS_OVF_FLAGS_EN
    logic             io_ovf_clr;
    logic             io_tx_overflow;
    logic             io_rx_underflow;
`endif

    modport slave (
`ifdef UART_FIFOS_OVF_FLAGS_EN
        input  io_ovf_clr,
        output io_tx_overflow, io_rx_underflow,
`endif
        input  io_rx_data_in, io_rx_data_in_valid, io_rx_pop,
        input  io_tx_wr_en, io_tx_wr_data, io_tx_data_out_ready,
        output io_rx_data_in_ready, io_rx_fifo_out, io_rx_fifo_empty,
        output io_tx_fifo_full, io_tx_data_out, io_tx_data_out_valid
    );

    modport master (
`ifdef UART_FIFOS_OVF_FLAGS_EN
        output io_ovf_clr,
        input  io_tx_overflow, io_rx_underflow,
`endif
        output io_rx_data_in, io_rx_data_in_valid, io_rx_pop,
        output io_tx_wr_en, io_tx_wr_data, io_tx_data_out_ready,
        input  io_rx_data_in_ready, io_rx_fifo_out, io_rx_fifo_empty,
        input  io_tx_fifo_full, io_tx_data_out, io_tx_data_out_valid
    );
endinterface

// File: rtl/uart_fifos.sv
// rtl/uart_fifos.sv - RX/TX circular byte FIFOs for UART MMIO; UART_FIFOS_OVF_FLAGS_EN adds sticky drop/underflow flags
module uart_fifos #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    uart_fifos_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [WIDTH-1:0] rx_mem_q [DEPTH];
    logic [WIDTH-1:0] tx_mem_q [DEPTH];

    ptr_t             rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    ptr_t             tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [WIDTH-1:0] rx_out_q, rx_out_d;

    logic rx_empty, rx_full, rx_push, rx_pop;
    logic tx_empty, tx_full, tx_push, tx_pop;

    // Accept decisions use start-of-cycle flags, so push-on-empty and pop-on-full always win.
    always_comb begin
        rx_empty  = (rx_wptr_q == rx_rptr_q);
        rx_full   = (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]) && (rx_wptr_q[AW] != rx_rptr_q[AW]);
        tx_empty  = (tx_wptr_q == tx_rptr_q);
        tx_full   = (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]) && (tx_wptr_q[AW] != tx_rptr_q[AW]);

        rx_push   = bus.io_rx_data_in_valid && !rx_full;
        rx_pop    = bus.io_rx_pop && !rx_empty;
        tx_push   = bus.io_tx_wr_en && !tx_full;
        tx_pop    = bus.io_tx_data_out_ready && !tx_empty;

        rx_wptr_d = rx_push ? rx_wptr_q + PTR_ONE : rx_wptr_q;
        rx_rptr_d = rx_pop  ? rx_rptr_q + PTR_ONE : rx_rptr_q;
        tx_wptr_d = tx_push ? tx_wptr_q + PTR_ONE : tx_wptr_q;
        tx_rptr_d = tx_pop  ? tx_rptr_q + PTR_ONE : tx_rptr_q;
        rx_out_d  = rx_pop  ? rx_mem_q[rx_rptr_q[AW-1:0]] : rx_out_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_out_q  <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_out_q  <= rx_out_d;
        end
    end

    // Storage arrays are deliberately left unreset; pointers alone define contents.
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= bus.io_rx_data_in;
        if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.io_tx_wr_data;
    end

    assign bus.io_rx_data_in_ready  = !rx_full;
    assign bus.io_rx_fifo_out       = rx_out_q;
    assign bus.io_rx_fifo_empty     = rx_empty;
    assign bus.io_tx_fifo_full      = tx_full;
    assign bus.io_tx_data_out       = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign bus.io_tx_data_out_valid = !tx_empty;

`ifdef UART_FIFOS_OVF_FLAGS_EN
    logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

    // Clear has priority over a set arriving in the same cycle.
    always_comb begin
        tx_ovf_d = tx_ovf_q || (bus.io_tx_wr_en && tx_full);
        rx_unf_d = rx_unf_q || (bus.io_rx_pop && rx_empty);
        if (bus.io_ovf_clr) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    assign bus.io_tx_overflow  = tx_ovf_q;
    assign bus.io_rx_underflow = rx_unf_q;
`endif
endmodule
